// File: rtl/mem_port_arbiter.sv
// Two-master, burst-aware round-robin arbiter in front of a single-port memory
// with 1-cycle read latency. Grants are combinational; read strobes are registered.
module mem_port_arbiter #(
  parameter int unsigned MAX_BURST = 88,
  parameter int unsigned CNT_W     = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [15:0] m0_addr,
  input  logic [31:0] m0_dataW,
  output logic        m0_gnt,
  output logic [31:0] m0_dataR,
  output logic        m0_rvalid,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [15:0] m1_addr,
  input  logic [31:0] m1_dataW,
  output logic        m1_gnt,
  output logic [31:0] m1_dataR,
  output logic        m1_rvalid,
  output logic [15:0] addr,
  output logic [31:0] dataW,
  output logic        en,
  output logic        we,
  input  logic [31:0] dataR
);

  typedef enum logic [1:0] {OwnNone, OwnM0, OwnM1} owner_e;

  localparam logic [CNT_W-1:0] MaxBurst = CNT_W'(MAX_BURST);

  owner_e           owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             rr_last_q, rr_last_d;
  logic             rd_pend0_q, rd_pend0_d;
  logic             rd_pend1_q, rd_pend1_d;
  logic             g0, g1, cap_hit;

  assign cap_hit = (MAX_BURST != 0) && (cnt_q >= MaxBurst);
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    if (!reset) begin
      if (owner_q == OwnM0 && m0_req && (!cap_hit || !m1_req)) begin
        g0 = 1'b1;
      end else if (owner_q == OwnM1 && m1_req && (!cap_hit || !m0_req)) begin
        g1 = 1'b1;
      end else if (owner_q == OwnM0 && m0_req) begin
        // Owner still wants the port but its burst is spent and m1 waits.
        g1 = 1'b1;
      end else if (owner_q == OwnM1 && m1_req) begin
        g0 = 1'b1;
      end else if (m0_req && m1_req) begin
        g0 = rr_last_q;
        g1 = ~rr_last_q;
      end else begin
        g0 = m0_req;
        g1 = m1_req;
      end
    end
  end

  always_comb begin
    owner_d    = OwnNone;
    cnt_d      = '0;
    rr_last_d  = rr_last_q;
    rd_pend0_d = g0 & ~m0_we;
    rd_pend1_d = g1 & ~m1_we;
    if (g0) begin
      owner_d   = OwnM0;
      rr_last_d = 1'b0;
      cnt_d     = (owner_q == OwnM0) ? cnt_inc : CNT_W'(1);
    end else if (g1) begin
      owner_d   = OwnM1;
      rr_last_d = 1'b1;
      cnt_d     = (owner_q == OwnM1) ? cnt_inc : CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q    <= OwnNone;
      cnt_q      <= '0;
      rr_last_q  <= 1'b1;
      rd_pend0_q <= 1'b0;
      rd_pend1_q <= 1'b0;
    end else begin
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      rr_last_q  <= rr_last_d;
      rd_pend0_q <= rd_pend0_d;
      rd_pend1_q <= rd_pend1_d;
    end
  end

  always_comb begin
    m0_gnt = g0;
    m1_gnt = g1;
    en     = g0 | g1;
    we     = (g0 & m0_we) | (g1 & m1_we);
    addr   = g0 ? m0_addr : (g1 ? m1_addr : 16'h0);
    dataW  = g0 ? m0_dataW : (g1 ? m1_dataW : 32'h0);
    // A strobe pending across a reset edge is dropped, not delivered.
    m0_rvalid = rd_pend0_q & ~reset;
    m1_rvalid = rd_pend1_q & ~reset;
    m0_dataR  = m0_rvalid ? dataR : 32'h0;
    m1_dataR  = m1_rvalid ? dataR : 32'h0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: two arbiters (burst cap 88 and 1) share stimulus and are
// compared against a behavioural grant model kept in integer form.
module tb_mem_port_arbiter;

  typedef logic [117:0] vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
  logic [15:0] m0_addr = '0, m1_addr = '0;
  logic [31:0] m0_dw = '0, m1_dw = '0, mem_dr = '0;

  logic [1:0]  d_g0, d_g1, d_rv0, d_rv1, d_en, d_we;
  logic [15:0] d_addr [2];
  logic [31:0] d_dw [2], d_dr0 [2], d_dr1 [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MAX_BURST(88), .CNT_W(8)) dut_a (
    .clk(clk), .reset(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_dataW(m0_dw),
    .m0_gnt(d_g0[0]), .m0_dataR(d_dr0[0]), .m0_rvalid(d_rv0[0]),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_dataW(m1_dw),
    .m1_gnt(d_g1[0]), .m1_dataR(d_dr1[0]), .m1_rvalid(d_rv1[0]),
    .addr(d_addr[0]), .dataW(d_dw[0]), .en(d_en[0]), .we(d_we[0]), .dataR(mem_dr)
  );

  mem_port_arbiter #(.MAX_BURST(1), .CNT_W(8)) dut_b (
    .clk(clk), .reset(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_dataW(m0_dw),
    .m0_gnt(d_g0[1]), .m0_dataR(d_dr0[1]), .m0_rvalid(d_rv0[1]),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_dataW(m1_dw),
    .m1_gnt(d_g1[1]), .m1_dataR(d_dr1[1]), .m1_rvalid(d_rv1[1]),
    .addr(d_addr[1]), .dataW(d_dw[1]), .en(d_en[1]), .we(d_we[1]), .dataR(mem_dr)
  );

  // Reference model: owner is -1/0/1, run is beats in the current ownership.
  int mown  [2] = '{-1, -1};
  int mrun  [2] = '{0, 0};
  int mlast [2] = '{1, 1};
  bit mpend0 [2] = '{1'b0, 1'b0};
  bit mpend1 [2] = '{1'b0, 1'b0};
  int eg    [2];

  function automatic int cap_of(int k);
    return (k == 0) ? 88 : 1;
  endfunction

  function automatic int pick(int own, int run, int last, logic r0, logic r1, int cap);
    logic mine, other;
    mine  = (own == 0) ? r0 : r1;
    other = (own == 0) ? r1 : r0;
    if (own >= 0 && mine && (cap == 0 || run < cap || !other)) return own;
    if (own >= 0 && mine) return 1 - own;
    if (r0 && r1) return 1 - last;
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      eg[k] = rst ? -1 : pick(mown[k], mrun[k], mlast[k], m0_req, m1_req, cap_of(k));
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        mown[k] <= -1; mrun[k] <= 0; mlast[k] <= 1; mpend0[k] <= 1'b0; mpend1[k] <= 1'b0;
      end else begin
        mpend0[k] <= (eg[k] == 0) && !m0_we;
        mpend1[k] <= (eg[k] == 1) && !m1_we;
        if (eg[k] < 0) begin
          mown[k] <= -1; mrun[k] <= 0;
        end else begin
          mrun[k]  <= (mown[k] == eg[k]) ? ((mrun[k] >= 255) ? 255 : mrun[k] + 1) : 1;
          mown[k]  <= eg[k];
          mlast[k] <= eg[k];
        end
      end
    end
  end

  function automatic vec_t exp_vec(int k);
    int g;
    logic rv0, rv1, w;
    logic [15:0] a;
    logic [31:0] d;
    g   = eg[k];
    rv0 = !rst && mpend0[k];
    rv1 = !rst && mpend1[k];
    w   = (g == 0) ? m0_we : ((g == 1) ? m1_we : 1'b0);
    a   = (g == 0) ? m0_addr : ((g == 1) ? m1_addr : 16'h0);
    d   = (g == 0) ? m0_dw : ((g == 1) ? m1_dw : 32'h0);
    return {g >= 0, w, g == 0, g == 1, rv0, rv1, a, d,
            rv0 ? mem_dr : 32'h0, rv1 ? mem_dr : 32'h0};
  endfunction

  function automatic vec_t dut_vec(int k);
    return {d_en[k], d_we[k], d_g0[k], d_g1[k], d_rv0[k], d_rv1[k], d_addr[k], d_dw[k],
            d_dr0[k], d_dr1[k]};
  endfunction

  // Requesters must hold their beat while stalled.
  logic        s0_q = 1'b0, s1_q = 1'b0;
  logic [48:0] h0_q, h1_q;
  always @(posedge clk) begin
    s0_q <= !rst && m0_req && !d_g0[0];
    s1_q <= !rst && m1_req && !d_g1[0];
    h0_q <= {m0_we, m0_addr, m0_dw};
    h1_q <= {m1_we, m1_addr, m1_dw};
  end
  always @(negedge clk) begin
    #2;
    if (s0_q && m0_req) assert ({m0_we, m0_addr, m0_dw} == h0_q) else $error("FAIL stall_hold m0");
    if (s1_q && m1_req) assert ({m1_we, m1_addr, m1_dw} == h1_q) else $error("FAIL stall_hold m1");
  end

  task automatic setin(input logic r, input logic q0, input logic w0, input logic [15:0] a0,
                       input logic [31:0] d0, input logic q1, input logic w1,
                       input logic [15:0] a1, input logic [31:0] d1);
    @(negedge clk);
    rst = r;
    m0_req = q0; m0_we = w0; m0_addr = a0; m0_dw = d0;
    m1_req = q1; m1_we = w1; m1_addr = a1; m1_dw = d1;
    mem_dr = $urandom;
    #4;
  endtask

  task automatic reset_dut();
    setin(1, 0, 0, 0, 0, 0, 0, 0, 0);
    setin(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      setin(1, 1, 1, 16'h1234, 32'hA5A5A5A5, 1, 0, 16'h4321, 32'h5A5A5A5A);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (dut_vec(k) !== '0) begin
          errors++;
          $display("FAIL reset_outputs[%0d]: got %h want 0", k, dut_vec(k));
        end
      end
    end
  endtask

  task automatic test_single_read();
    reset_dut();
    setin(0, 1, 0, 16'h0000, 32'h0, 0, 0, 0, 0);
    checks++;
    if ({d_g0[0], d_en[0], d_we[0], d_addr[0]} !== {3'b110, 16'h0000}) begin
      errors++;
      $display("FAIL read_issue: got gnt/en/we/addr %b%b%b/%h want 110/0000",
               d_g0[0], d_en[0], d_we[0], d_addr[0]);
    end
    setin(0, 0, 0, 0, 0, 0, 0, 0, 0);
    mem_dr = 32'hDEADBEEF;
    #1;
    checks++;
    if ({d_rv0[0], d_dr0[0], d_rv1[0]} !== {1'b1, 32'hDEADBEEF, 1'b0}) begin
      errors++;
      $display("FAIL read_return: got rv0=%b data=%h rv1=%b want 1 deadbeef 0",
               d_rv0[0], d_dr0[0], d_rv1[0]);
    end
  endtask

  task automatic test_contention();
    reset_dut();
    for (int i = 0; i < 96; i++) begin
      setin(0, 1, 0, 16'h0100, 32'h0, 1, 1, 16'h0200, 32'h11112222);
      checks++;
      if ({d_g0[0], d_g1[0], d_en[0]} !== {i < 88, i >= 88, 1'b1}) begin
        errors++;
        $display("FAIL contention beat %0d: got g0=%b g1=%b en=%b want %0d %0d 1",
                 i, d_g0[0], d_g1[0], d_en[0], i < 88, i >= 88);
      end
      if (i == 88) begin
        checks++;
        if (d_addr[0] !== 16'h0200) begin
          errors++;
          $display("FAIL contention_switch_addr: got %h want 0200", d_addr[0]);
        end
      end
    end
  endtask

  task automatic test_solo_stream();
    reset_dut();
    for (int i = 0; i < 300; i++) begin
      setin(0, 0, 0, 0, 0, 1, 1, 16'(16'h6300 + i), 32'(32'hC0DE0000 + i));
      checks++;
      if ({d_g1[0], d_we[0], d_addr[0]} !== {2'b11, 16'(16'h6300 + i)}) begin
        errors++;
        $display("FAIL solo_stream beat %0d: got g1=%b we=%b addr=%h want 1 1 %h",
                 i, d_g1[0], d_we[0], d_addr[0], 16'(16'h6300 + i));
      end
    end
    // Counter has saturated far beyond the cap, so a waiting m0 must win now.
    setin(0, 1, 0, 16'h0010, 0, 1, 1, 16'h642C, 32'h0);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({d_g0[k], d_g1[k]} !== 2'b10) begin
        errors++;
        $display("FAIL solo_yield[%0d]: got g0=%b g1=%b want 1 0", k, d_g0[k], d_g1[k]);
      end
    end
  endtask

  task automatic test_alternate();
    reset_dut();
    for (int i = 0; i < 5; i++) begin
      if (i < 4) setin(0, 1, 0, 16'h0010, 0, 1, 1, 16'h6300, 32'hCAFEF00D);
      else setin(0, 0, 0, 0, 0, 0, 0, 0, 0);
      checks++;
      if ({d_g0[1], d_g1[1], d_rv0[1], d_rv1[1]} !==
          {i < 4 && i % 2 == 0, i < 4 && i % 2 == 1, i % 2 == 1, 1'b0}) begin
        errors++;
        $display("FAIL alternate cyc %0d: got g0=%b g1=%b rv0=%b rv1=%b", i,
                 d_g0[1], d_g1[1], d_rv0[1], d_rv1[1]);
      end
    end
  endtask

  task automatic test_reset_midread();
    reset_dut();
    setin(0, 0, 0, 0, 0, 1, 0, 16'h4000, 0);
    checks++;
    if (d_g1[0] !== 1'b1) begin
      errors++;
      $display("FAIL midread_grant: got %b want 1", d_g1[0]);
    end
    setin(1, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (d_rv1[0] !== 1'b0) begin
      errors++;
      $display("FAIL midread_drop: got rv1=%b want 0", d_rv1[0]);
    end
    setin(0, 1, 0, 16'h0001, 0, 1, 0, 16'h0002, 0);
    checks++;
    if ({d_g0[0], d_g1[0], d_rv1[0]} !== 3'b100) begin
      errors++;
      $display("FAIL midread_tie: got g0=%b g1=%b rv1=%b want 1 0 0",
               d_g0[0], d_g1[0], d_rv1[0]);
    end
  endtask

  task automatic test_idle();
    reset_dut();
    for (int i = 0; i < 3; i++) setin(0, 1, 1, 16'(16'h0020 + i), 32'hFACE0000, 0, 0, 0, 0);
    setin(0, 0, 1, 16'hFFFF, 32'hFFFFFFFF, 0, 1, 16'hEEEE, 32'hEEEEEEEE);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({d_en[k], d_we[k], d_g0[k], d_g1[k], d_addr[k], d_dw[k]} !== '0) begin
        errors++;
        $display("FAIL idle[%0d]: got en=%b we=%b addr=%h dataW=%h want all 0",
                 k, d_en[k], d_we[k], d_addr[k], d_dw[k]);
      end
    end
    setin(0, 0, 0, 0, 0, 1, 0, 16'h0777, 0);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({d_g0[k], d_g1[k], d_addr[k]} !== {2'b01, 16'h0777}) begin
        errors++;
        $display("FAIL idle_wake[%0d]: got g0=%b g1=%b addr=%h want 0 1 0777",
                 k, d_g0[k], d_g1[k], d_addr[k]);
      end
    end
  endtask

  task automatic test_random();
    logic r0 = 0, w0 = 0, r1 = 0, w1 = 0;
    logic [15:0] a0 = 0, a1 = 0;
    logic [31:0] x0 = 0, x1 = 0;
    bit hold0, hold1;
    int phase;
    reset_dut();
    for (int c = 0; c < 3000; c++) begin
      hold0 = r0 && (eg[0] != 0);
      hold1 = r1 && (eg[0] != 1);
      phase = (c / 200) % 2;
      if (!hold0) begin
        r0 = (phase == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        w0 = 1'($urandom_range(0, 1)); a0 = 16'($urandom); x0 = $urandom;
      end
      if (!hold1) begin
        r1 = (phase == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        w1 = 1'($urandom_range(0, 1)); a1 = 16'($urandom); x1 = $urandom;
      end
      setin(0, r0, w0, a0, x0, r1, w1, a1, x1);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (dut_vec(k) !== exp_vec(k)) begin
          errors++;
          $display("FAIL random[%0d] cyc %0d: got %h want %h", k, c, dut_vec(k), exp_vec(k));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_solo_stream();
    test_alternate();
    test_reset_midread();
    test_idle();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
